md_rotate_unit: RTL and testbench

Execution unit for the PowerISA 3.0B MD/MDS-form doubleword rotates: rldicl, rldicr, rldic, rldimi, rldcl and rldcr. It sits downstream of the MD-format decoder and consumes that decoder's raw field outputs unchanged. It performs the sh/mb field swizzles itself, then runs a fixed-latency multi-cycle rotate, mask and merge sequence. It returns the 64-bit result, plus CR0 when Rc is set.

---
 rtl/md_pkg.sv | 37 +++
 rtl/md_mask_gen.sv | 13 +
 rtl/md_rotate_unit.sv | 179 +++++++++++++++++
 tb/tb_md_rotate_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the MD/MDS-form doubleword rotate unit: op encodings,
// FSM states and the big-endian mask generator.
package md_pkg;

    localparam int unsigned DATA_W = 64;

    typedef enum logic [2:0] {
        OP_RLDICL = 3'd0,
        OP_RLDICR = 3'd1,
        OP_RLDIC  = 3'd2,
        OP_RLDIMI = 3'd3,
        OP_RLDCX  = 3'd4
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROT_HI,
        ST_ROT_LO,
        ST_MASK
    } md_state_e;

    // Ones from big-endian bit mb through me inclusive, wrapping past bit 63 when mb > me.
    function automatic logic [DATA_W-1:0] md_mask(input logic [5:0] mb, input logic [5:0] me);
        logic [DATA_W-1:0] m;
        logic [5:0]        k;
        m = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            k = 6'(i);
            if (mb <= me)
                m[~k] = (k >= mb) && (k <= me);
            else
                m[~k] = (k >= mb) || (k <= me);
        end
        return m;
    endfunction

endpackage

// File: rtl/md_mask_gen.sv
// Combinational (mb, me) to 64-bit rotate mask, including the wrap case.
// Shared between the MD-form and M-form rotate units.
module md_mask_gen
    import md_pkg::*;
(
    input  logic [5:0]        i_mb,
    input  logic [5:0]        i_me,
    output logic [DATA_W-1:0] o_mask
);

    assign o_mask = md_mask(i_mb, i_me);

endmodule

// File: rtl/md_rotate_unit.sv
// PowerISA MD/MDS-form doubleword rotate unit (rldicl/rldicr/rldic/rldimi/rldcl/rldcr).
// Fixed 4-cycle sequence: accept, rotate by bytes, rotate by bits, mask/merge.
module md_rotate_unit
    import md_pkg::*;
#(
    parameter int unsigned opcodeWidth = 6,
    parameter int unsigned regWidth    = 5,
    parameter int unsigned immWidth    = 6,
    parameter int unsigned dataWidth   = 64
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic [2:0]           op_i,
    input  logic [regWidth-1:0]  sh_lo_i,
    input  logic [immWidth-1:0]  mb_raw_i,
    input  logic                 bit1_i,
    input  logic                 rc_i,
    input  logic [dataWidth-1:0] rs_data_i,
    input  logic [dataWidth-1:0] rb_data_i,
    input  logic [dataWidth-1:0] ra_data_i,
    input  logic                 so_i,
    output logic [dataWidth-1:0] result_o,
    output logic [3:0]           cr0_o,
    output logic                 cr0_valid_o,
    output logic                 done_o,
    output logic                 busy_o,
    output logic                 illegal_o
);

    localparam int unsigned UNUSED_OPCODE_W = opcodeWidth;

    md_state_e            r_state;
    md_op_e               r_op;
    logic                 r_bit1;
    logic                 r_rc;
    logic                 r_so;
    logic [5:0]           r_n;
    logic [5:0]           r_sh;
    logic [5:0]           r_m;
    logic [dataWidth-1:0] r_rot;
    logic [dataWidth-1:0] r_ra;
    logic [dataWidth-1:0] r_result;
    logic [3:0]           r_cr0;
    logic                 r_cr0_valid;
    logic                 r_done;
    logic                 r_illegal;

    logic [5:0]           w_sh;
    logic [5:0]           w_m;
    logic [5:0]           w_n;
    logic                 w_legal;
    logic [6:0]           w_hi_amt;
    logic [6:0]           w_lo_amt;
    logic [dataWidth-1:0] w_rot_hi;
    logic [dataWidth-1:0] w_rot_lo;
    logic [5:0]           w_mb;
    logic [5:0]           w_me;
    logic [DATA_W-1:0]    w_mask;
    logic [dataWidth-1:0] w_masked;
    logic [dataWidth-1:0] w_result;
    logic                 w_unused_rb;

    // mb/me field is stored with its high bit last in the instruction word.
    assign w_sh    = {bit1_i, sh_lo_i};
    assign w_m     = {mb_raw_i[0], mb_raw_i[immWidth-1:1]};
    assign w_n     = (op_i == OP_RLDCX) ? rb_data_i[5:0] : w_sh;
    assign w_legal = (op_i <= OP_RLDCX);

    assign w_unused_rb = ^rb_data_i[dataWidth-1:6];

    assign w_hi_amt = {1'b0, r_n[5:3], 3'b000};
    assign w_lo_amt = {4'b0000, r_n[2:0]};
    assign w_rot_hi = (r_rot << w_hi_amt) | (r_rot >> (7'd64 - w_hi_amt));
    assign w_rot_lo = (r_rot << w_lo_amt) | (r_rot >> (7'd64 - w_lo_amt));

    always_comb begin
        w_mb = r_m;
        w_me = 6'd63;
        case (r_op)
            OP_RLDICL: begin w_mb = r_m;   w_me = 6'd63;  end
            OP_RLDICR: begin w_mb = 6'd0;  w_me = r_m;    end
            OP_RLDIC,
            OP_RLDIMI: begin w_mb = r_m;   w_me = ~r_sh;  end
            OP_RLDCX: begin
                if (r_bit1) begin
                    w_mb = 6'd0;
                    w_me = r_m;
                end else begin
                    w_mb = r_m;
                    w_me = 6'd63;
                end
            end
            default: begin w_mb = r_m; w_me = 6'd63; end
        endcase
    end

    md_mask_gen u_mask_gen (
        .i_mb   (w_mb),
        .i_me   (w_me),
        .o_mask (w_mask)
    );

    assign w_masked = r_rot & w_mask;
    assign w_result = (r_op == OP_RLDIMI) ? (w_masked | (r_ra & ~w_mask)) : w_masked;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_RLDICL;
            r_bit1      <= 1'b0;
            r_rc        <= 1'b0;
            r_so        <= 1'b0;
            r_n         <= '0;
            r_sh        <= '0;
            r_m         <= '0;
            r_rot       <= '0;
            r_ra        <= '0;
            r_result    <= '0;
            r_cr0       <= '0;
            r_cr0_valid <= 1'b0;
            r_done      <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_illegal   <= 1'b0;
            r_cr0_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable_i) begin
                        if (w_legal) begin
                            r_op    <= md_op_e'(op_i);
                            r_bit1  <= bit1_i;
                            r_rc    <= rc_i;
                            r_so    <= so_i;
                            r_n     <= w_n;
                            r_sh    <= w_sh;
                            r_m     <= w_m;
                            r_rot   <= rs_data_i;
                            r_ra    <= ra_data_i;
                            r_state <= ST_ROT_HI;
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                ST_ROT_HI: begin
                    r_rot   <= w_rot_hi;
                    r_state <= ST_ROT_LO;
                end
                ST_ROT_LO: begin
                    r_rot   <= w_rot_lo;
                    r_state <= ST_MASK;
                end
                ST_MASK: begin
                    r_result <= w_result;
                    r_done   <= 1'b1;
                    if (r_rc) begin
                        r_cr0       <= {w_result[dataWidth-1],
                                        ~w_result[dataWidth-1] & (|w_result),
                                        ~(|w_result),
                                        r_so};
                        r_cr0_valid <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign result_o    = r_result;
    assign cr0_o       = r_cr0;
    assign cr0_valid_o = r_cr0_valid;
    assign done_o      = r_done;
    assign busy_o      = (r_state != ST_IDLE);
    assign illegal_o   = r_illegal;

endmodule

// File: tb/tb_md_rotate_unit.sv
// Directed + randomized bench for md_rotate_unit; expected results are queued at
// issue time and compared when done_o pulses.
module tb_md_rotate_unit;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  cr0;
        logic        cv;
        int          due;
    } item_t;

    logic        clk = 1'b0;
    logic        rst, en, bit1, rc, so;
    logic [2:0]  op;
    logic [4:0]  shl;
    logic [5:0]  mbr;
    logic [63:0] rs, rb, ra;
    logic [63:0] result;
    logic [3:0]  cr0;
    logic        cv, done, busy, ill;

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    item_t q[$];
    logic [3:0] exp_last = 4'b0000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    md_rotate_unit #(
        .opcodeWidth (6),
        .regWidth    (5),
        .immWidth    (6),
        .dataWidth   (64)
    ) dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .enable_i    (en),
        .op_i        (op),
        .sh_lo_i     (shl),
        .mb_raw_i    (mbr),
        .bit1_i      (bit1),
        .rc_i        (rc),
        .rs_data_i   (rs),
        .rb_data_i   (rb),
        .ra_data_i   (ra),
        .so_i        (so),
        .result_o    (result),
        .cr0_o       (cr0),
        .cr0_valid_o (cv),
        .done_o      (done),
        .busy_o      (busy),
        .illegal_o   (ill)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        item_t it;
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_done", {63'b0, done}, 64'd0);
            end else begin
                it = q.pop_front();
                chk("result", result, it.res);
                chk("cr0_valid", {63'b0, cv}, {63'b0, it.cv});
                chk("cr0", {60'b0, cr0}, {60'b0, it.cr0});
                chk("latency", 64'(cyc), 64'(it.due));
            end
        end
    end

    function automatic logic [63:0] ref_rotl(input logic [63:0] v, input int n);
        if (n == 0) return v;
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [63:0] ref_mask(input int x, input int y);
        logic [63:0] mk;
        logic        hit;
        mk = 64'd0;
        for (int p = 0; p < 64; p++) begin
            if (x <= y) hit = (p >= x) && (p <= y);
            else        hit = (p >= x) || (p <= y);
            if (hit) mk[63 - p] = 1'b1;
        end
        return mk;
    endfunction

    task automatic issue(input logic [2:0] o, input logic b1, input logic [4:0] s,
                         input logic [5:0] mb, input logic r, input logic [63:0] vrs,
                         input logic [63:0] vrb, input logic [63:0] vra, input logic vso,
                         input bit push, input logic [63:0] eres, input logic [3:0] ecr0,
                         input logic ecv);
        item_t it;
        @(negedge clk);
        op = o; bit1 = b1; shl = s; mbr = mb; rc = r;
        rs = vrs; rb = vrb; ra = vra; so = vso; en = 1'b1;
        if (push) begin
            it.res = eres; it.cr0 = ecr0; it.cv = ecv; it.due = cyc + 4;
            q.push_back(it);
        end
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic model_issue(input logic [2:0] o, input logic b1, input logic [4:0] s,
                               input logic [5:0] mb, input logic r, input logic [63:0] vrs,
                               input logic [63:0] vrb, input logic [63:0] vra, input logic vso);
        int sh, m, n, x, y;
        logic [63:0] rot, mk, res;
        logic [3:0]  c;
        sh = int'(b1) * 32 + int'(s);
        m  = int'(mb[0]) * 32 + int'(mb >> 1);
        n  = (o == 3'd4) ? int'(vrb & 64'h3F) : sh;
        case (o)
            3'd0:    begin x = m; y = 63; end
            3'd1:    begin x = 0; y = m;  end
            3'd4:    begin if (b1) begin x = 0; y = m; end else begin x = m; y = 63; end end
            default: begin x = m; y = 63 - sh; end
        endcase
        rot = ref_rotl(vrs, n);
        mk  = ref_mask(x, y);
        res = rot & mk;
        if (o == 3'd3) res = res | (vra & ~mk);
        if (r) c = {res[63], !res[63] && (res != 0), res == 0, vso};
        else   c = exp_last;
        exp_last = c;
        issue(o, b1, s, mb, r, vrs, vrb, vra, vso, 1'b1, res, c, r);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; op = '0; bit1 = 1'b0; shl = '0; mbr = '0;
        rc = 1'b0; so = 1'b0; rs = '0; rb = '0; ra = '0;
        repeat (2) @(negedge clk);
        chk("reset_result", result, 64'd0);
        chk("reset_cr0", {60'b0, cr0}, 64'd0);
        chk("reset_flags", {59'b0, cv, done, busy, ill}, 64'd0);
        rst = 1'b0;

        // rldicl: rotate left 4, full mask
        issue(3'd0, 1'b0, 5'd4, 6'd0, 1'b0, 64'h0123456789ABCDEF, 64'd0, 64'd0, 1'b0,
              1'b1, 64'h123456789ABCDEF0, 4'b0000, 1'b0);
        chk("busy_after_accept", {63'b0, busy}, 64'd1);
        wait_drain();
        chk("idle_after_done", {63'b0, busy}, 64'd0);

        // rldicr: me=31
        issue(3'd1, 1'b0, 5'd0, 6'b111110, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 64'd0, 1'b0,
              1'b1, 64'hFFFFFFFF00000000, 4'b0000, 1'b0);
        wait_drain();

        // rldimi: sh=56 inserts low byte into the top byte of RA
        issue(3'd3, 1'b1, 5'd24, 6'd0, 1'b0, 64'h00000000000000FF, 64'd0,
              64'h1111111111111111, 1'b0, 1'b1, 64'hFF11111111111111, 4'b0000, 1'b0);
        wait_drain();

        // rldcl with Rc: rotate by rb low six bits = 3
        issue(3'd4, 1'b0, 5'd0, 6'b111100, 1'b1, 64'h8000000000000001, 64'h43, 64'd0, 1'b0,
              1'b1, 64'h000000000000000C, 4'b0100, 1'b1);
        exp_last = 4'b0100;
        wait_drain();

        // back-to-back: second op issued in the done cycle of the first
        model_issue(3'd2, 1'b1, 5'd8, 6'b100101, 1'b1, 64'hDEADBEEFCAFEF00D, 64'd0, 64'd0, 1'b1);
        repeat (2) @(negedge clk);
        model_issue(3'd1, 1'b0, 5'd0, 6'd0, 1'b0, 64'h8000000000000000, 64'd0, 64'd0, 1'b0);
        wait_drain();

        // illegal op
        issue(3'd6, 1'b0, 5'd3, 6'd0, 1'b0, 64'h1234, 64'd0, 64'd0, 1'b0,
              1'b0, 64'd0, 4'b0000, 1'b0);
        chk("illegal_pulse", {62'b0, ill, busy}, 64'b10);
        @(negedge clk);
        chk("illegal_one_cycle", {62'b0, ill, busy}, 64'b00);

        // enable while busy is ignored
        model_issue(3'd0, 1'b1, 5'd31, 6'd0, 1'b0, 64'h0F0F0F0F0F0F0F0F, 64'd0, 64'd0, 1'b0);
        op = 3'd1; shl = 5'd9; rs = 64'hAAAA5555AAAA5555; en = 1'b1;
        @(negedge clk);
        chk("busy_hold1", {63'b0, busy}, 64'd1);
        @(negedge clk);
        chk("busy_hold2", {63'b0, busy}, 64'd1);
        @(negedge clk);
        en = 1'b0;
        wait_drain();
        repeat (6) @(negedge clk);
        chk("no_extra_op", {63'b0, busy}, 64'd0);

        // reset in ROT_LO drops the op; reset also beats a simultaneous enable
        issue(3'd0, 1'b0, 5'd1, 6'd0, 1'b1, 64'hFFFF, 64'd0, 64'd0, 1'b1,
              1'b0, 64'd0, 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", {62'b0, busy, done}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_cr0", {60'b0, cr0}, 64'd0);
        op = 3'd0; rs = 64'h55; en = 1'b1;
        @(negedge clk);
        chk("rst_beats_enable", {63'b0, busy}, 64'd0);
        rst = 1'b0; en = 1'b0;
        exp_last = 4'b0000;
        repeat (6) @(negedge clk);
        model_issue(3'd3, 1'b0, 5'd16, 6'b011111, 1'b1, 64'h00000000FFFF0000, 64'd0,
                    64'h0123456789ABCDEF, 1'b0);
        wait_drain();

        // boundaries: rldic sh=63, rldcr n=0, rldicl m=63
        model_issue(3'd2, 1'b1, 5'd31, 6'b000011, 1'b0, 64'h8000000000000001, 64'd0, 64'd0, 1'b0);
        wait_drain();
        model_issue(3'd4, 1'b1, 5'd0, 6'b111111, 1'b1, 64'h7FFFFFFFFFFFFFFF, 64'hFFC0, 64'd0, 1'b1);
        wait_drain();
        model_issue(3'd0, 1'b0, 5'd0, 6'b111111, 1'b1, 64'h0, 64'd0, 64'd0, 1'b0);
        wait_drain();

        for (int i = 0; i < 14; i++) begin
            model_issue(3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)),
                        1'($urandom_range(0, 1)), {$urandom, $urandom},
                        {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            wait_drain();
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
